// File: rtl/icache_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : icache_unit                                                   |
// | Purpose  : Direct-mapped, read-only instruction cache with two-word      |
// |            blocks. Zero-latency combinational hit path towards fetch,    |
// |            two-beat block fill from the memory controller on a miss,     |
// |            and a sticky halt state that reports quiescence.              |
// | Ports    : CLK, RST (async, active high)                                 |
// |            icache_REN/addr/halt  -> fetch request and halt               |
// |            icache_hit/load/halted <- lookup result and halt status       |
// |            mem_REN/addr -> memory read, mem_wait/load <- memory reply    |
// | Options  : ICACHE_PERF_CNT_EN adds icache_hit_count/icache_miss_count.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module icache_unit #(
  parameter int ICACHE_FRAMES     = 8,
  parameter int LOG_ICACHE_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        icache_REN,
  input  logic [31:0] icache_addr,
  input  logic        icache_halt,
  output logic        icache_hit,
  output logic [31:0] icache_load,
  output logic        icache_halted,
  output logic        mem_REN,
  output logic [31:0] mem_addr,
  input  logic        mem_wait,
  input  logic [31:0] mem_load
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] icache_hit_count,
  output logic [31:0] icache_miss_count
`endif
);

  localparam int TAG_W = 13 - LOG_ICACHE_FRAMES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL0  = 2'd1,
    FILL1  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Frame storage. Only the valid bits need a reset; tag/data are qualified
  // by valid so they are left unreset.
  logic [ICACHE_FRAMES-1:0] r_valid;
  logic [TAG_W-1:0]         r_tag   [ICACHE_FRAMES];
  logic [31:0]              r_word0 [ICACHE_FRAMES];
  logic [31:0]              r_word1 [ICACHE_FRAMES];

  // Miss bookkeeping: the block being filled and its first word.
  logic [TAG_W-1:0]             r_miss_tag;
  logic [LOG_ICACHE_FRAMES-1:0] r_miss_index;
  logic [31:0]                  r_fill_word0;

  logic                         w_offset;
  logic [LOG_ICACHE_FRAMES-1:0] w_index;
  logic [TAG_W-1:0]             w_tag;
  logic                         w_lookup_hit;
  logic                         w_miss;
  logic                         w_word0_we;
  logic                         w_fill_we;
  logic                         w_unused_addr_bits;

  assign w_offset = icache_addr[2];
  assign w_index  = icache_addr[2+LOG_ICACHE_FRAMES:3];
  assign w_tag    = icache_addr[15:3+LOG_ICACHE_FRAMES];

  // Upper half and byte offset of the address are don't-care.
  assign w_unused_addr_bits = ^{icache_addr[31:16], icache_addr[1:0]};

  assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    icache_hit    = 1'b0;
    icache_load   = 32'h0;
    icache_halted = 1'b0;
    mem_REN       = 1'b0;
    mem_addr      = 32'h0;
    w_miss        = 1'b0;
    w_word0_we    = 1'b0;
    w_fill_we     = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Halt takes priority over any request presented in the same cycle.
        if (icache_halt) begin
          w_next_state = HALTED;
        end else if (icache_REN && w_lookup_hit) begin
          icache_hit  = 1'b1;
          icache_load = w_offset ? r_word1[w_index] : r_word0[w_index];
        end else if (icache_REN) begin
          w_miss       = 1'b1;
          w_next_state = FILL0;
        end
      end

      FILL0: begin
        mem_REN  = 1'b1;
        mem_addr = {16'h0, r_miss_tag, r_miss_index, 1'b0, 2'b00};
        if (!mem_wait) begin
          w_word0_we   = 1'b1;
          w_next_state = FILL1;
        end
      end

      FILL1: begin
        mem_REN  = 1'b1;
        mem_addr = {16'h0, r_miss_tag, r_miss_index, 1'b1, 2'b00};
        if (!mem_wait) begin
          w_fill_we    = 1'b1;
          w_next_state = IDLE;
        end
      end

      HALTED: begin
        icache_halted = 1'b1;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, valid bits and miss registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_fill_word0 <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_miss) begin
        r_miss_tag   <= w_tag;
        r_miss_index <= w_index;
      end
      if (w_word0_we) begin
        r_fill_word0 <= mem_load;
      end
      if (w_fill_we) begin
        r_valid[r_miss_index] <= 1'b1;
      end
    end
  end

  // Tag/data write happens together with the valid set on the last beat;
  // an abandoned fill never reaches this point because reset clears the FSM.
  always_ff @(posedge CLK) begin
    if (w_fill_we) begin
      r_tag[r_miss_index]   <= r_miss_tag;
      r_word0[r_miss_index] <= r_fill_word0;
      r_word1[r_miss_index] <= mem_load;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32). Hits and misses can
  // only occur in IDLE, so both freeze naturally while halted.
  // --------------------------------------------------------------------------
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if ((r_state == IDLE) && icache_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign icache_hit_count  = r_hit_count;
  assign icache_miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_icache_unit                                                |
// | Purpose  : Directed, scoreboarded bench for icache_unit. Memory model    |
// |            returns an address-derived word; expected fetch data is       |
// |            queued when a request is driven and compared on the hit.      |
// | Options  : honours ICACHE_PERF_CNT_EN (counter ports and checks).        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_icache_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        icache_REN;
  logic [31:0] icache_addr;
  logic        icache_halt;
  logic        icache_hit;
  logic [31:0] icache_load;
  logic        icache_halted;
  logic        mem_REN;
  logic [31:0] mem_addr;
  logic        mem_wait;
  logic [31:0] mem_load;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] icache_hit_count;
  logic [31:0] icache_miss_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_waits  = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  logic [3:0]  wcnt;
  logic [31:0] exp_q [$];
  logic [31:0] ren_q [$];
  logic [31:0] acc_q [$];

  icache_unit dut (
    .CLK           (CLK),
    .RST           (RST),
    .icache_REN    (icache_REN),
    .icache_addr   (icache_addr),
    .icache_halt   (icache_halt),
    .icache_hit    (icache_hit),
    .icache_load   (icache_load),
    .icache_halted (icache_halted),
    .mem_REN       (mem_REN),
    .mem_addr      (mem_addr),
    .mem_wait      (mem_wait),
    .mem_load      (mem_load)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .icache_hit_count  (icache_hit_count),
    .icache_miss_count (icache_miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA0000 + ((a - 32'h40) >> 2);
  endfunction

  // Memory model: n_waits busy cycles before each accepted beat.
  assign mem_wait = mem_REN && (int'(wcnt) < n_waits);
  assign mem_load = mem_word(mem_addr);

  always @(posedge CLK) begin
    if (!mem_REN || !mem_wait) wcnt <= 4'd0;
    else                       wcnt <= wcnt + 4'd1;
  end

  // Memory bus monitor: every request cycle and every accepted beat.
  always @(negedge CLK) begin
    if (mem_REN) ren_q.push_back(mem_addr);
    if (mem_REN && !mem_wait) acc_q.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic perf_check(input string tag);
`ifdef ICACHE_PERF_CNT_EN
    check({tag, " hit_count"},  icache_hit_count,  32'(exp_hits));
    check({tag, " miss_count"}, icache_miss_count, 32'(exp_miss));
`else
    if (tag.len() == 0) $display("perf counters not built");
`endif
  endtask

  task automatic check_fill(input string tag, input logic [31:0] blk);
    check({tag, " beats"}, 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check({tag, " beat0 addr"}, acc_q[0], blk);
      check({tag, " beat1 addr"}, acc_q[1], blk + 32'd4);
    end
  endtask

  // Issue a request and hold it until the hit; checks data, latency and
  // the memory traffic it caused.
  task automatic fetch(input logic [31:0] a, input int exp_lat, input bit exp_fill,
                       input string tag);
    int lat;
    bit got;
    logic [31:0] blk;
    blk = {a[31:3], 3'b000};
    ren_q.delete();
    acc_q.delete();
    icache_REN  = 1'b1;
    icache_addr = a;
    exp_q.push_back(mem_word(a));
    #1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (icache_hit === 1'b1) got = 1'b1;
      else begin
        cyc();
        lat++;
      end
    end
    check({tag, " hit"}, {31'b0, got}, 32'd1);
    if (got) begin
      check({tag, " load"}, icache_load, exp_q.pop_front());
      exp_hits++;
    end else begin
      void'(exp_q.pop_front());
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_fill) exp_miss++;
    cyc();
    icache_REN = 1'b0;
    #1;
    if (exp_fill) begin
      check_fill(tag, blk);
      check({tag, " req cycles"}, 32'(ren_q.size()), 32'(2 * (n_waits + 1)));
      if (ren_q.size() == 2 * (n_waits + 1)) begin
        for (int i = 0; i < ren_q.size(); i++) begin
          check({tag, " req addr"}, ren_q[i], (i <= n_waits) ? blk : blk + 32'd4);
        end
      end
    end else begin
      check({tag, " no mem req"}, 32'(ren_q.size()), 32'd0);
    end
  endtask

  initial begin
    icache_REN  = 1'b0;
    icache_addr = 32'h0;
    icache_halt = 1'b0;

    // Reset state
    #2;
    check("rst hit",    {31'b0, icache_hit},    32'd0);
    check("rst load",   icache_load,            32'd0);
    check("rst halted", {31'b0, icache_halted}, 32'd0);
    check("rst mem_REN", {31'b0, mem_REN},      32'd0);
    check("rst mem_addr", mem_addr,             32'd0);
    perf_check("rst");
    @(posedge CLK);
    #3 RST = 1'b0;
    cyc();

    // Cold miss, then hits on both words of the block
    fetch(32'h40, 3, 1'b1, "cold_miss");
    fetch(32'h44, 0, 1'b0, "cold_hit_w1");
    fetch(32'h40, 0, 1'b0, "cold_hit_w0");

    // Wait states: three busy cycles per beat
    n_waits = 3;
    fetch(32'h100, 9, 1'b1, "wait_miss");
    n_waits = 0;
    fetch(32'h104, 0, 1'b0, "wait_hit");

    // Conflict eviction on index 0
    fetch(32'h80, 3, 1'b1, "evict_fill");
    fetch(32'h40, 3, 1'b1, "evict_remiss");
    perf_check("after evict");

    // Redirect during FILL0: latched block completes first
    ren_q.delete();
    acc_q.delete();
    icache_REN  = 1'b1;
    icache_addr = 32'h200;
    #1;
    check("redir miss hit", {31'b0, icache_hit}, 32'd0);
    exp_miss++;
    cyc();
    check("redir fill0 REN", {31'b0, mem_REN}, 32'd1);
    icache_addr = 32'h300;
    exp_q.push_back(mem_word(32'h300));
    #1;
    check("redir fill0 addr", mem_addr, 32'h200);
    check("redir fill0 hit", {31'b0, icache_hit}, 32'd0);
    cyc();
    check("redir fill1 addr", mem_addr, 32'h204);
    cyc();
    check("redir idle hit", {31'b0, icache_hit}, 32'd0);
    check("redir idle REN", {31'b0, mem_REN}, 32'd0);
    check_fill("redir first", 32'h200);
    exp_miss++;
    cyc();
    check("redir 2nd fill0 addr", mem_addr, 32'h300);
    cyc();
    check("redir 2nd fill1 addr", mem_addr, 32'h304);
    cyc();
    check("redir final hit", {31'b0, icache_hit}, 32'd1);
    check("redir final load", icache_load, exp_q.pop_front());
    exp_hits++;
    cyc();
    icache_REN = 1'b0;
    fetch(32'h304, 0, 1'b0, "redir_hit_w1");
    perf_check("after redir");

    // Halt arriving during FILL1
    ren_q.delete();
    acc_q.delete();
    icache_REN  = 1'b1;
    icache_addr = 32'h200;
    #1;
    exp_miss++;
    cyc();
    cyc();
    icache_halt = 1'b1;
    #1;
    check("halt fill1 REN",    {31'b0, mem_REN},       32'd1);
    check("halt fill1 halted", {31'b0, icache_halted}, 32'd0);
    cyc();
    check("halt idle hit",    {31'b0, icache_hit},    32'd0);
    check("halt idle REN",    {31'b0, mem_REN},       32'd0);
    check("halt idle halted", {31'b0, icache_halted}, 32'd0);
    check_fill("halt fill", 32'h200);
    cyc();
    cyc();
    check("halted flag",    {31'b0, icache_halted}, 32'd1);
    check("halted mem_REN", {31'b0, mem_REN},       32'd0);
    check("halted hit",     {31'b0, icache_hit},    32'd0);
    check("halted load",    icache_load,            32'd0);
    icache_halt = 1'b0;
    cyc();
    check("halted sticky", {31'b0, icache_halted}, 32'd1);
    perf_check("halted");

    // Reset out of HALTED, then halt with REN on a cached word in IDLE
    RST = 1'b1;
    icache_REN = 1'b0;
    #2;
    check("rst exits halt", {31'b0, icache_halted}, 32'd0);
    exp_hits = 0;
    exp_miss = 0;
    RST = 1'b0;
    cyc();
    fetch(32'h40, 3, 1'b1, "post_halt_fill");
    icache_halt = 1'b1;
    icache_REN  = 1'b1;
    icache_addr = 32'h40;
    #1;
    check("idle halt hit",  {31'b0, icache_hit}, 32'd0);
    check("idle halt load", icache_load,         32'd0);
    cyc();
    check("idle halt halted", {31'b0, icache_halted}, 32'd1);

    // Reset in the middle of a fill
    RST = 1'b1;
    icache_REN  = 1'b0;
    icache_halt = 1'b0;
    #2;
    RST = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    cyc();
    fetch(32'h40, 3, 1'b1, "pre_rst_fill");
    icache_REN  = 1'b1;
    icache_addr = 32'h80;
    #1;
    cyc();
    check("midfill REN before rst", {31'b0, mem_REN}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check("midfill rst REN",  {31'b0, mem_REN}, 32'd0);
    check("midfill rst addr", mem_addr,         32'd0);
    exp_hits = 0;
    exp_miss = 0;
    perf_check("midfill rst");
    icache_REN = 1'b0;
    #1 RST = 1'b0;
    cyc();
    fetch(32'h40, 3, 1'b1, "post_rst_remiss");
    perf_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/icache_unit.md
Name: icache_unit

Overview:
- Direct-mapped, read-only instruction cache.
- Serves fetch-side word requests (REN/addr in, hit/load out) and fills two-word blocks from the memory controller on a miss.
- Sits between the fetch stage and the memory arbiter in core; supplies the combinational hit/load pair the fetch stage samples each cycle.
- Supports a halt handshake that freezes the cache and reports quiescence to core control.

Parameters:
- ICACHE_FRAMES, 8, number of direct-mapped frames (power of 2, ≥2).
- LOG_ICACHE_FRAMES, 3, log2(ICACHE_FRAMES).

Ports:
- CLK  in  1  clock, posedge.
- RST  in  1  asynchronous active-high reset.
- icache_REN  in  1  fetch read request.
- icache_addr  in  32  byte address; only [15:2] used, [31:16] and [1:0] ignored.
- icache_halt  in  1  enter halted state.
- icache_hit  out  1  requested word valid this cycle.
- icache_load  out  32  requested instruction word.
- icache_halted  out  1  cache idle and frozen.
- mem_REN  out  1  memory read request.
- mem_addr  out  32  memory byte address, {16'h0, addr[15:2], 2'b00}.
- mem_wait  in  1  memory busy; data valid when mem_REN & ~mem_wait.
- mem_load  in  32  memory read data.

Behaviour:
- Address split (16-bit space):
  - word offset = addr[2]
  - index = addr[2+LOG_ICACHE_FRAMES:3]
  - tag = addr[15:3+LOG_ICACHE_FRAMES], 13-LOG_ICACHE_FRAMES bits (10 at default).
- Frame contents: valid bit, tag, two 32-bit words.
- Reset:
  - all valid = 0, state = IDLE.
  - icache_hit = 0, icache_load = 0, icache_halted = 0, mem_REN = 0, mem_addr = 0.
  - Reset asserted mid-fill abandons the fill immediately; no frame is written.
- States: IDLE, FILL0, FILL1, HALTED.
- IDLE:
  - Hit is combinational, zero latency: icache_hit = icache_REN & valid[index] & tag match & ~icache_halt.
  - icache_load = frame word[offset] when hit, else 32'h0.
  - Miss (REN & ~hit & ~icache_halt): latch tag/index into miss registers, next state FILL0.
  - icache_halt = 1: next state HALTED; halt wins over a simultaneous REN.
- FILL0:
  - mem_REN = 1, mem_addr = {16'h0, miss_tag, miss_index, 1'b0, 2'b00}.
  - On ~mem_wait: capture mem_load into buffer word0, go to FILL1.
- FILL1:
  - mem_REN = 1, mem_addr offset bit = 1.
  - On ~mem_wait: write {valid = 1, miss_tag, word0, mem_load} into frame miss_index, go to IDLE.
  - mem_REN drops the cycle after the last word is accepted.
- During FILL0/FILL1:
  - icache_hit = 0 regardless of REN/addr.
  - Changes to icache_addr do not redirect the fill; the latched miss block always completes.
  - The new address is looked up in IDLE afterwards and may miss again.
- icache_halt during a fill: the fill completes, then IDLE sees halt and goes to HALTED. Halt is sticky only via the state.
- HALTED:
  - icache_hit = 0, mem_REN = 0, icache_halted = 1.
  - Exits only on reset.
- Miss latency: ≥3 cycles from the miss cycle to the hit cycle with mem_wait = 0 (FILL0, FILL1, then IDLE hit). Each mem_wait cycle adds one.
- Replacement: a fill overwrites a valid frame unconditionally; there is no write path and no coherence.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- When defined:
  - Adds outputs icache_hit_count[31:0] and icache_miss_count[31:0], both reset to 0.
  - hit_count increments on each IDLE cycle with icache_hit = 1.
  - miss_count increments on each IDLE→FILL0 transition.
  - Both counters wrap at 2^32 and freeze in HALTED.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, REN = 1, addr = 0x0000_0040, mem_wait = 0, mem_load = 0xAAAA0000 then 0xAAAA0001 → mem_addr 0x40 then 0x44; icache_hit = 1 with load 0xAAAA0000 on the 4th cycle; addr 0x44 then hits with 0xAAAA0001 with no mem_REN.
- Wait states: miss at 0x0100 with mem_wait high for 3 cycles per word → mem_addr stays 0x100 during the waits; hit occurs 9 cycles after the miss; icache_hit = 0 throughout.
- Conflict eviction: fill 0x0040, then miss at 0x0080 (same index 0 at default, different tag) → refill; re-access of 0x0040 misses again (mem_REN = 1, mem_addr 0x40).
- Redirect mid-fill: miss 0x0200, change addr to 0x0300 during FILL0 → fill completes to 0x200/0x204, then a new miss is issued with mem_addr 0x300.
- Halt: assert icache_halt during FILL1 → frame written, then icache_halted = 1, mem_REN = 0, icache_hit = 0 even for the now-cached 0x200; halt with REN in IDLE → no hit.
- Reset mid-fill: assert RST in FILL0 → mem_REN = 0 immediately; after release, the previously filled address misses; with ICACHE_PERF_CNT_EN, counters read 0.
